clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Time-set controller for the binary clock. Two push-buttons (mode, inc) drive a state machine that freezes the hours/minutes/seconds counter chain, edits shadow copies of hours and minutes, and commits them with a one-cycle load strobe. It sits between the board buttons and the clock counter chain. It also drives blank masks so the display blinks the field being edited.

Parameters:
DEBOUNCE_CS, 3, consecutive cs_tick samples a button level must hold before it is accepted
TIMEOUT_CS, 1000, cs_tick count with no accepted press in a set state before abandoning the edit (10 s)
BLINK_CS, 25, cs_tick count per blink half-period (2 Hz blink)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cs_tick  in  1  one-clk strobe at 100 Hz; timebase for debounce, timeout and blink
btn_mode  in  1  raw mode button, active-high, asynchronous to clk
btn_inc  in  1  raw increment button, active-high, asynchronous to clk
cur_hours  in  5  live hours count, 0..23
cur_minutes  in  6  live minutes count, 0..59
hold  out  1  high in every set state; clock chain stops counting while high
load  out  1  one-clk strobe; clock chain loads load_hours/load_minutes and clears seconds and centiseconds
load_hours  out  5  shadow hours, 0..23
load_minutes  out  6  shadow minutes, 0..59
blank_h  out  1  display blanks the hours field while high
blank_m  out  1  display blanks the minutes field while high

Behaviour:
- Reset (async): state RUN. hold, load, blank_h and blank_m are 0. load_hours and load_minutes are 0. All counters are cleared.
- Button path: 2-flop synchronizer, then debounce. The synchronized level is sampled only on cs_tick. The accepted level changes after DEBOUNCE_CS consecutive equal samples. A press event is a one-clk pulse on the accepted 0->1 edge. Releases produce no event.
- States: RUN, SET_H, SET_M, COMMIT.
- RUN: on a mode press, copy cur_hours/cur_minutes into the shadows and go to SET_H. inc presses are ignored.
- SET_H: on an inc press, load_hours increments and wraps 23->0. On a mode press, go to SET_M.
- SET_M: on an inc press, load_minutes increments and wraps 59->0. On a mode press, go to COMMIT.
- COMMIT: lasts exactly one clk. load=1 during that clk, then go to RUN.
- hold is registered: 1 in SET_H, SET_M and COMMIT, 0 in RUN. It falls on the clk the state becomes RUN.
- Latency: state changes on the clk after the press event.
- Mode and inc press events in the same clk: mode wins and the inc is dropped.
- Timeout: the counter clears on any accepted press and on entry to SET_H. It counts on cs_tick while in SET_H or SET_M. On reaching TIMEOUT_CS, go to RUN with no load pulse; the clock resumes from its frozen value.
- Blink: a counter toggles a phase bit every BLINK_CS cs_ticks. The phase resets to 1 on every state change and every inc press.
  - blank_h = (state==SET_H) & phase.
  - blank_m = (state==SET_M) & phase.
  - Otherwise both are 0.
- Shadow values are never out of range. Values beyond 23/59 cannot arise, because the shadows are loaded only from in-range inputs and wrap.
- Reset during SET_H or SET_M: return to RUN immediately, with no load and hold=0.

Optional Feature:
AUTOREPEAT_EN.
- Defined: while inc stays accepted-high in SET_H or SET_M, a synthetic inc press occurs after 50 cs_ticks, then every 10 cs_ticks until release. Synthetic presses also clear the timeout counter.
- Undefined: one increment per physical press only. The repeat counter is not instantiated.

Decomposition:
- Package binary_clock_pkg holds:
  - HOURS_PER_DAY=24, MIN_PER_HOUR=60, HOUR_W=5, MIN_W=6
  - set_state_t enum {RUN, SET_H, SET_M, COMMIT}
- Sub-module button_debounce (synchronizer, debounce counter and press-event pulse; parameter DEBOUNCE_CS) is instantiated once per button.
- Counter widths are $clog2 of the parameters.

Test Plan:
- cur=13:45. Press mode, release, press mode, press mode, each debounced -> hold=1 from the clk after the first press event; exactly one load pulse with load_hours=13, load_minutes=45; hold=0 the clk after.
- In SET_H with shadow 22, two inc presses -> load_hours 23 then 0. In SET_M with shadow 59, one inc press -> 0.
- Button bounce: with DEBOUNCE_CS=3, toggle btn_inc every cs_tick for 10 ticks, then hold high -> exactly one increment, 3 cs_ticks after the level holds high.
- Enter SET_H with no further presses -> after 1000 cs_ticks: state RUN, hold=0, no load pulse. blank_h toggles every 25 cs_ticks before that.
- Force mode and inc press events in the same clk in SET_H -> state SET_M, load_hours unchanged. Assert rst while in SET_M -> immediately hold=0, load=0, blanks=0.
- AUTOREPEAT_EN defined: hold inc for 100 cs_ticks in SET_M starting from 0 -> load_minutes=6 (1 at press, repeats at +50, 60, 70, 80, 90).

Source files
------------

// File: rtl/binary_clock_pkg.sv
// Shared types and constants for the binary clock: field widths, day/hour limits,
// the time-set state encoding and wrap-around helpers for the shadow registers.
package binary_clock_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;
    localparam int HOUR_W        = 5;
    localparam int MIN_W         = 6;

    typedef enum logic [1:0] {
        RUN,
        SET_H,
        SET_M,
        COMMIT
    } set_state_t;

    function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
        return (h == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : h + HOUR_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] next_minute(input logic [MIN_W-1:0] m);
        return (m == MIN_W'(MIN_PER_HOUR - 1)) ? '0 : m + MIN_W'(1);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_debounce.sv
// button_debounce: two-flop synchronizer, cs_tick-sampled debounce and a one-clk
// press pulse on the accepted rising edge. Releases produce no pulse.
module button_debounce #(
    parameter int DEBOUNCE_CS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_tick,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CS > 1) ? $clog2(DEBOUNCE_CS) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt tracks consecutive samples that disagree with the accepted level
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (cs_tick) begin
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CS - 1)) begin
                    level_d = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time-set FSM that freezes the clock chain, edits shadow
// hours/minutes, commits them with a load strobe and blinks the edited field.
// Optional: define AUTOREPEAT_EN for held-button auto-increment.
module clock_set_ctrl
    import binary_clock_pkg::*;
#(
    parameter int DEBOUNCE_CS = 3,
    parameter int TIMEOUT_CS  = 1000,
    parameter int BLINK_CS    = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_tick,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    output logic              hold,
    output logic              load,
    output logic [HOUR_W-1:0] load_hours,
    output logic [MIN_W-1:0]  load_minutes,
    output logic              blank_h,
    output logic              blank_m
);

    localparam int TMO_W = (TIMEOUT_CS > 1) ? $clog2(TIMEOUT_CS) : 1;
    localparam int BLK_W = (BLINK_CS > 1) ? $clog2(BLINK_CS) : 1;

    logic mode_level, mode_press;
    logic inc_level, inc_press;
    logic inc_evt, rpt_evt, in_set;
    logic unused_levels;

    set_state_t        state_q, state_d;
    logic              hold_q, hold_d;
    logic              load_q, load_d;
    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  minutes_q, minutes_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [BLK_W-1:0]  blink_q, blink_d;
    logic              phase_q, phase_d;

    button_debounce #(.DEBOUNCE_CS(DEBOUNCE_CS)) u_mode_btn (
        .clk     (clk),
        .rst     (rst),
        .cs_tick (cs_tick),
        .btn     (btn_mode),
        .level   (mode_level),
        .press   (mode_press)
    );

    button_debounce #(.DEBOUNCE_CS(DEBOUNCE_CS)) u_inc_btn (
        .clk     (clk),
        .rst     (rst),
        .cs_tick (cs_tick),
        .btn     (btn_inc),
        .level   (inc_level),
        .press   (inc_press)
    );

    assign unused_levels = mode_level ^ inc_level;
    assign in_set        = (state_q == SET_H) || (state_q == SET_M);

`ifdef AUTOREPEAT_EN
    localparam int RPT_FIRST_CS = 50;
    localparam int RPT_NEXT_CS  = 10;
    localparam int RPT_W        = $clog2(RPT_FIRST_CS);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;

    // First repeat after a long delay, then a faster cadence until release
    always_comb begin
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        rpt_evt     = 1'b0;
        if (!inc_level || !in_set) begin
            rpt_d       = '0;
            rpt_first_d = 1'b1;
        end else if (cs_tick) begin
            if (rpt_q == (rpt_first_q ? RPT_W'(RPT_FIRST_CS - 1) : RPT_W'(RPT_NEXT_CS - 1))) begin
                rpt_evt     = 1'b1;
                rpt_d       = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_evt = 1'b0;
`endif

    assign inc_evt = inc_press | rpt_evt;

    // Mode beats inc in the same clk; any press preempts the timeout count
    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        tmo_d     = tmo_q;
        blink_d   = blink_q;
        phase_d   = phase_q;

        if (cs_tick) begin
            if (blink_q == BLK_W'(BLINK_CS - 1)) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BLK_W'(1);
            end
        end

        if (state_q == COMMIT) begin
            state_d = RUN;
        end else if (mode_press) begin
            tmo_d = '0;
            case (state_q)
                RUN: begin
                    hours_d   = cur_hours;
                    minutes_d = cur_minutes;
                    state_d   = SET_H;
                end
                SET_H:   state_d = SET_M;
                SET_M:   state_d = COMMIT;
                default: state_d = RUN;
            endcase
        end else if (inc_evt) begin
            tmo_d = '0;
            if (state_q == SET_H) begin
                hours_d = next_hour(hours_q);
            end else if (state_q == SET_M) begin
                minutes_d = next_minute(minutes_q);
            end
        end else if (in_set && cs_tick) begin
            if (tmo_q == TMO_W'(TIMEOUT_CS - 1)) begin
                tmo_d   = '0;
                state_d = RUN;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        if ((state_d != state_q) || inc_evt) begin
            phase_d = 1'b1;
            blink_d = '0;
        end

        hold_d = (state_d != RUN);
        load_d = (state_d == COMMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            hold_q    <= 1'b0;
            load_q    <= 1'b0;
            hours_q   <= '0;
            minutes_q <= '0;
            tmo_q     <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            load_q    <= load_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            tmo_q     <= tmo_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
        end
    end

    assign hold         = hold_q;
    assign load         = load_q;
    assign load_hours   = hours_q;
    assign load_minutes = minutes_q;
    assign blank_h      = (state_q == SET_H) & phase_q;
    assign blank_m      = (state_q == SET_M) & phase_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: directed and random button sequences, one cs_tick per
// step, checked against a tick-level behavioural model of the time-set rules.
module tb_clock_set_ctrl;

    localparam int DEB   = 3;
    localparam int TMO   = 1000;
    localparam int BLINK = 25;
    localparam int RUN_S  = 0;
    localparam int SETH_S = 1;
    localparam int SETM_S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_tick;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       hold;
    logic       load;
    logic [4:0] load_hours;
    logic [5:0] load_minutes;
    logic       blank_h;
    logic       blank_m;

    int testsRun = 0;
    int testsFailed = 0;

    int loadSeen = 0;
    int lastLoadH = -1;
    int lastLoadM = -1;

    int mState, shH, shM, tCnt, bCnt, holdTicks;
    int expLoads = 0;
    int expLoadH = -1;
    int expLoadM = -1;
    bit phase, accM, accI;
    int cntM, cntI;

    always #5 clk = ~clk;

    clock_set_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cs_tick      (cs_tick),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .hold         (hold),
        .load         (load),
        .load_hours   (load_hours),
        .load_minutes (load_minutes),
        .blank_h      (blank_h),
        .blank_m      (blank_m)
    );

    // Counts load strobes seen between clock edges along with the committed values
    always @(negedge clk) begin
        if (load === 1'b1) begin
            loadSeen  = loadSeen + 1;
            lastLoadH = int'(load_hours);
            lastLoadM = int'(load_minutes);
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mState = RUN_S; shH = 0; shM = 0; tCnt = 0; bCnt = 0; holdTicks = 0;
        phase = 1'b1; accM = 1'b0; accI = 1'b0; cntM = 0; cntI = 0;
    endtask

    task automatic debounceStep(input bit s, inout bit acc, inout int cnt, output bit ev);
        ev = 1'b0;
        if (s != acc) begin
            cnt++;
            if (cnt == DEB) begin
                ev  = s;
                acc = s;
                cnt = 0;
            end
        end else begin
            cnt = 0;
        end
    endtask

    task automatic doInc();
        if (mState == SETH_S) shH = (shH + 1) % 24;
        if (mState == SETM_S) shM = (shM + 1) % 60;
        if (mState != RUN_S) begin
            tCnt = 0; phase = 1'b1; bCnt = 0;
        end
    endtask

    task automatic modelTick(input bit m, input bit i);
        bit modeEv, incEv, synth;
        synth = 1'b0;
`ifdef AUTOREPEAT_EN
        if (mState != RUN_S && accI) begin
            holdTicks++;
            if (holdTicks >= 50 && (holdTicks - 50) % 10 == 0) synth = 1'b1;
        end else begin
            holdTicks = 0;
        end
`endif
        if (synth) begin
            doInc();
        end else if (mState != RUN_S) begin
            tCnt++;
            if (tCnt == TMO) begin
                mState = RUN_S; tCnt = 0;
            end else begin
                bCnt++;
                if (bCnt == BLINK) begin
                    phase = !phase; bCnt = 0;
                end
            end
        end
        debounceStep(m, accM, cntM, modeEv);
        debounceStep(i, accI, cntI, incEv);
        if (modeEv) begin
            tCnt = 0; phase = 1'b1; bCnt = 0;
            if (mState == RUN_S) begin
                shH = int'(cur_hours); shM = int'(cur_minutes); mState = SETH_S;
            end else if (mState == SETH_S) begin
                mState = SETM_S;
            end else begin
                expLoads++; expLoadH = shH; expLoadM = shM; mState = RUN_S;
            end
        end else if (incEv) begin
            doInc();
        end
    endtask

    task automatic checkOutput(input string ctx);
        checkVal({ctx, ".hold"}, hold, (mState != RUN_S));
        checkVal({ctx, ".load"}, load, 0);
        checkVal({ctx, ".load_hours"}, load_hours, shH);
        checkVal({ctx, ".load_minutes"}, load_minutes, shM);
        checkVal({ctx, ".blank_h"}, blank_h, (mState == SETH_S) && phase);
        checkVal({ctx, ".blank_m"}, blank_m, (mState == SETM_S) && phase);
        checkVal({ctx, ".load_count"}, loadSeen, expLoads);
        checkVal({ctx, ".last_load_h"}, lastLoadH, expLoadH);
        checkVal({ctx, ".last_load_m"}, lastLoadM, expLoadM);
    endtask

    // One cs_tick per call: buttons settle through the synchronizer, then the tick fires
    task automatic applyStimulus(input string ctx, input bit m, input bit i);
        btn_mode = m;
        btn_inc  = i;
        repeat (3) @(negedge clk);
        cs_tick = 1'b1;
        modelTick(m, i);
        @(negedge clk);
        cs_tick = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput(ctx);
    endtask

    task automatic pressMode(input string ctx);
        repeat (4) applyStimulus(ctx, 1'b1, 1'b0);
        repeat (4) applyStimulus(ctx, 1'b0, 1'b0);
    endtask

    task automatic pressInc(input string ctx);
        repeat (4) applyStimulus(ctx, 1'b0, 1'b1);
        repeat (4) applyStimulus(ctx, 1'b0, 1'b0);
    endtask

    task automatic pulseReset();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(negedge clk);
    endtask

    initial begin
        bit rm, ri;
        rst = 1'b1; cs_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        cur_hours = 5'd0; cur_minutes = 6'd0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset");
        rst = 1'b0;
        @(negedge clk);

        cur_hours = 5'd13; cur_minutes = 6'd45;
        pressMode("enter");
        checkVal("enter.hold", hold, 1);
        pressMode("to_m");
        pressMode("commit");
        checkVal("commit.count", loadSeen, 1);
        checkVal("commit.hours", lastLoadH, 13);
        checkVal("commit.minutes", lastLoadM, 45);
        checkVal("commit.hold", hold, 0);

        cur_hours = 5'd22; cur_minutes = 6'd59;
        pressMode("wrap_enter");
        pressInc("wrap_h1");
        checkVal("wrap.h23", load_hours, 23);
        pressInc("wrap_h2");
        checkVal("wrap.h0", load_hours, 0);
        pressMode("wrap_to_m");
        pressInc("wrap_m");
        checkVal("wrap.m0", load_minutes, 0);
        pressMode("wrap_commit");
        checkVal("wrap.commit_h", lastLoadH, 0);
        checkVal("wrap.commit_m", lastLoadM, 0);

        cur_hours = 5'd5; cur_minutes = 6'd10;
        pressMode("bounce_enter");
        for (int k = 0; k < 10; k++) applyStimulus("bounce", 1'b0, (k % 2) == 0);
        checkVal("bounce.no_inc", load_hours, 5);
        repeat (5) applyStimulus("bounce_hold", 1'b0, 1'b1);
        repeat (4) applyStimulus("bounce_rel", 1'b0, 1'b0);
        checkVal("bounce.one_inc", load_hours, 6);

        repeat (TMO + 10) applyStimulus("timeout", 1'b0, 1'b0);
        checkVal("timeout.hold", hold, 0);
        checkVal("timeout.no_load", loadSeen, 2);

        cur_hours = 5'd7; cur_minutes = 6'd30;
        pressMode("same_enter");
        repeat (4) applyStimulus("same_clk", 1'b1, 1'b1);
        repeat (4) applyStimulus("same_rel", 1'b0, 1'b0);
        checkVal("same.hours", load_hours, 7);
        checkVal("same.in_m", blank_m, 1);

        #2 rst = 1'b1;
        #1;
        checkVal("rst.hold", hold, 0);
        checkVal("rst.load", load, 0);
        checkVal("rst.blank_h", blank_h, 0);
        checkVal("rst.blank_m", blank_m, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(negedge clk);

        rm = 1'b0; ri = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(3) == 0) rm = !rm;
            if ($urandom_range(3) == 0) ri = !ri;
            if ($urandom_range(15) == 0) begin
                cur_hours   = 5'($urandom_range(23));
                cur_minutes = 6'($urandom_range(59));
            end
            applyStimulus("random", rm, ri);
        end
        repeat (4) applyStimulus("random_rel", 1'b0, 1'b0);

`ifdef AUTOREPEAT_EN
        pulseReset();
        cur_hours = 5'd0; cur_minutes = 6'd0;
        pressMode("rpt_enter");
        pressMode("rpt_to_m");
        repeat (100) applyStimulus("rpt_hold", 1'b0, 1'b1);
        checkVal("rpt.minutes", load_minutes, 6);
        repeat (4) applyStimulus("rpt_rel", 1'b0, 1'b0);
`else
        pulseReset();
        checkOutput("final_reset");
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
